// File: rtl/jtag_debug_scan_engine.sv
// jtag_debug_scan_engine: debug data-register scan engine driven by virtual TAP strobes.
// Captures a per-instruction word, shifts it serially through tdi/tdo, and hands
// each completed update to the core through a valid/ready action handshake.
// DR_W is expected to lie in 8..64.
module jtag_debug_scan_engine #(
  parameter int IR_W = 2,
  parameter int DR_W = 38
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IR_W-1:0]          ir_in,
  input  logic                     vs_uir,
  input  logic                     vs_cdr,
  input  logic                     vs_sdr,
  input  logic                     vs_udr,
  input  logic                     tdi,
  output logic                     tdo,
  input  logic [(2**IR_W)*DR_W-1:0] capture_data,
  output logic [DR_W-1:0]          jdo,
  output logic                     act_valid,
  input  logic                     act_ready,
  output logic [IR_W-1:0]          act_ch,
  output logic                     act_take,
  output logic                     act_short,
  output logic                     overflow,
  input  logic                     clr_overflow,
  output logic                     st_idle
);

  localparam int NUM_CH = 2**IR_W;
  localparam int CNT_W = $clog2(DR_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DR_W);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state;
  logic [DR_W-1:0]   sr;
  logic [CNT_W-1:0]  cnt;
  logic [IR_W-1:0]   ir_q;
  logic [DR_W-1:0]   cap_sel;
  logic              udr_hit;
  logic              accept;
  logic              ovf_set;

  // Capture word of the channel addressed by the current instruction.
  always_comb begin
    cap_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ir_q == IR_W'(k)) cap_sel = capture_data[k*DR_W +: DR_W];
    end
  end

  // Update-DR only counts when no update-IR wins the cycle and a scan is open;
  // a transfer completing in the same cycle frees the action slot for it.
  always_comb begin
    udr_hit = vs_udr && !vs_uir && (state == SHIFT);
    accept  = udr_hit && (!act_valid || act_ready);
    ovf_set = udr_hit && act_valid && !act_ready;
  end

  assign tdo     = sr[0];
  assign st_idle = (state == IDLE);

  // Scan FSM, shift register, action handshake and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      ir_q      <= '0;
      jdo       <= '0;
      act_valid <= 1'b0;
      act_ch    <= '0;
      act_take  <= 1'b0;
      act_short <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (act_valid && act_ready) act_valid <= 1'b0;

      if (vs_uir) begin
        ir_q <= ir_in;
        if (state == SHIFT) state <= IDLE;
      end else if (vs_udr) begin
        if (state == SHIFT) begin
          if (accept) begin
            jdo       <= sr;
            act_ch    <= ir_q;
            act_take  <= sr[DR_W-1];
            act_short <= (cnt != CNT_MAX);
            act_valid <= 1'b1;
          end
          state <= IDLE;
        end
      end else if (vs_sdr) begin
        if (state == SHIFT) begin
          sr <= {tdi, sr[DR_W-1:1]};
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end
      end else if (vs_cdr) begin
        sr    <= cap_sel;
        cnt   <= '0;
        state <= SHIFT;
      end

      if (ovf_set)           overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_debug_scan_engine.sv
// tb_jtag_debug_scan_engine: directed self-checking bench for the scan engine.
// Expected actions are queued when an update is issued and compared when the
// DUT presents them on the action interface.
module tb_jtag_debug_scan_engine;

  localparam int IR_W = 2;
  localparam int DR_W = 38;
  localparam int NUM_CH = 4;

  typedef struct packed {
    logic [DR_W-1:0] jdo;
    logic [IR_W-1:0] ch;
    logic            take;
    logic            shrt;
  } act_t;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [IR_W-1:0]          ir_in;
  logic                     vs_uir, vs_cdr, vs_sdr, vs_udr;
  logic                     tdi;
  logic                     tdo;
  logic [NUM_CH*DR_W-1:0]   capture_data;
  logic [DR_W-1:0]          jdo;
  logic                     act_valid;
  logic                     act_ready;
  logic [IR_W-1:0]          act_ch;
  logic                     act_take;
  logic                     act_short;
  logic                     overflow;
  logic                     clr_overflow;
  logic                     st_idle;

  act_t            sb[$];
  int              checks = 0;
  int              fails = 0;
  logic [DR_W-1:0] msr;
  logic [5:0]      mcnt;
  logic [IR_W-1:0] mir;
  logic [DR_W-1:0] first_jdo;

  jtag_debug_scan_engine #(.IR_W(IR_W), .DR_W(DR_W)) dut (
    .clk(clk), .reset(reset), .ir_in(ir_in),
    .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
    .tdi(tdi), .tdo(tdo), .capture_data(capture_data), .jdo(jdo),
    .act_valid(act_valid), .act_ready(act_ready), .act_ch(act_ch),
    .act_take(act_take), .act_short(act_short), .overflow(overflow),
    .clr_overflow(clr_overflow), .st_idle(st_idle)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DR_W-1:0] chan(input logic [IR_W-1:0] k);
    return capture_data[int'(k)*DR_W +: DR_W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    vs_uir = 1'b0; vs_cdr = 1'b0; vs_sdr = 1'b0; vs_udr = 1'b0;
    clr_overflow = 1'b0;
  endtask

  task automatic doUir(input logic [IR_W-1:0] v);
    ir_in = v; vs_uir = 1'b1; tick(); mir = v;
  endtask

  task automatic doCdr();
    vs_cdr = 1'b1; tick(); msr = chan(mir); mcnt = '0;
  endtask

  task automatic doSdr(input logic b);
    tdi = b; vs_sdr = 1'b1; tick();
    msr = {b, msr[DR_W-1:1]};
    if (mcnt < 6'(DR_W)) mcnt++;
  endtask

  task automatic pushExpected();
    act_t e;
    e.jdo = msr; e.ch = mir; e.take = msr[DR_W-1]; e.shrt = (mcnt != 6'(DR_W));
    sb.push_back(e);
  endtask

  // Waits (bounded) for a presented action and compares it with the oldest expectation.
  task automatic popCompare(input string tag);
    act_t e;
    int n = 0;
    while (act_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checkVal({tag, "_valid"}, 64'(act_valid), 64'd1);
    if (sb.size() == 0) begin
      checkVal({tag, "_sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      checkVal({tag, "_jdo"},   64'(jdo),       64'(e.jdo));
      checkVal({tag, "_ch"},    64'(act_ch),    64'(e.ch));
      checkVal({tag, "_take"},  64'(act_take),  64'(e.take));
      checkVal({tag, "_short"}, 64'(act_short), 64'(e.shrt));
    end
  endtask

  initial begin
    reset = 1'b1; ir_in = '0; tdi = 1'b0; act_ready = 1'b0; clr_overflow = 1'b0;
    vs_uir = 1'b0; vs_cdr = 1'b0; vs_sdr = 1'b0; vs_udr = 1'b0;
    capture_data = '0;
    capture_data[0*DR_W +: DR_W] = 38'h00_0000_000F;
    capture_data[1*DR_W +: DR_W] = 38'h15_1234_5678;
    capture_data[2*DR_W +: DR_W] = 38'h2A_AAAA_AAAA;
    capture_data[3*DR_W +: DR_W] = 38'h0C_DEAD_BEEF;
    msr = '0; mcnt = '0; mir = '0;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    checkVal("rst_st_idle",   64'(st_idle),   64'd1);
    checkVal("rst_tdo",       64'(tdo),       64'd0);
    checkVal("rst_jdo",       64'(jdo),       64'd0);
    checkVal("rst_act_valid", 64'(act_valid), 64'd0);
    checkVal("rst_overflow",  64'(overflow),  64'd0);

    // Scenario 1: full scan of channel 2 with tdi=1
    doUir(2'd2);
    doCdr();
    checkVal("s1_st_shift", 64'(st_idle), 64'd0);
    checkVal("s1_tdo_0", 64'(tdo), 64'd0);
    for (int i = 0; i < DR_W; i++) begin
      doSdr(1'b1);
      if (i < DR_W - 1) checkVal($sformatf("s1_tdo_%0d", i + 1), 64'(tdo), 64'((i + 1) % 2));
    end
    pushExpected();
    vs_udr = 1'b1; tick();
    checkVal("s1_latency", 64'(act_valid), 64'd1);
    checkVal("s1_jdo_const", 64'(jdo), 64'h3F_FFFF_FFFF);
    popCompare("s1");
    checkVal("s1_idle", 64'(st_idle), 64'd1);
    act_ready = 1'b1; tick();
    checkVal("s1_valid_drop", 64'(act_valid), 64'd0);

    // Scenario 2: short scan of channel 1, five bits shifted in
    doUir(2'd1);
    doCdr();
    doSdr(1'b1); doSdr(1'b0); doSdr(1'b1); doSdr(1'b1); doSdr(1'b0);
    pushExpected();
    vs_udr = 1'b1; tick();
    checkVal("s2_jdo_const", 64'(jdo), 64'({5'b01101, 33'(38'h15_1234_5678 >> 5)}));
    popCompare("s2");
    tick();
    checkVal("s2_valid_drop", 64'(act_valid), 64'd0);

    // Scenario 3: backpressure, overflow, set-vs-clear and same-cycle acceptance
    act_ready = 1'b0;
    doUir(2'd3);
    doCdr();
    for (int i = 0; i < DR_W; i++) doSdr(1'(i % 2));
    pushExpected();
    first_jdo = msr;
    vs_udr = 1'b1; tick();
    checkVal("s3_valid_a", 64'(act_valid), 64'd1);
    doCdr();
    for (int i = 0; i < DR_W; i++) doSdr(1'b0);
    vs_udr = 1'b1; tick();
    checkVal("s3_overflow", 64'(overflow), 64'd1);
    checkVal("s3_jdo_kept", 64'(jdo), 64'(first_jdo));
    checkVal("s3_valid_kept", 64'(act_valid), 64'd1);
    checkVal("s3_idle", 64'(st_idle), 64'd1);
    clr_overflow = 1'b1; tick();
    checkVal("s3_clear", 64'(overflow), 64'd0);
    doCdr();
    vs_udr = 1'b1; clr_overflow = 1'b1; tick();
    checkVal("s3_set_wins", 64'(overflow), 64'd1);
    clr_overflow = 1'b1; tick();
    checkVal("s3_clear2", 64'(overflow), 64'd0);
    doCdr();
    for (int i = 0; i < 4; i++) doSdr(1'b1);
    popCompare("s3a");
    act_ready = 1'b1;
    pushExpected();
    vs_udr = 1'b1; tick();
    checkVal("s3_same_cycle_no_ovf", 64'(overflow), 64'd0);
    popCompare("s3b");
    tick();
    checkVal("s3_valid_drop", 64'(act_valid), 64'd0);

    // Scenario 4: simultaneous strobes abort the scan; sdr in IDLE is ignored
    doUir(2'd0);
    doCdr();
    doSdr(1'b0); doSdr(1'b0); doSdr(1'b0);
    checkVal("s4_tdo_pre", 64'(tdo), 64'(msr[0]));
    ir_in = 2'd2; vs_uir = 1'b1; vs_udr = 1'b1; vs_sdr = 1'b1; tdi = 1'b0; tick();
    mir = 2'd2;
    checkVal("s4_idle", 64'(st_idle), 64'd1);
    checkVal("s4_no_valid", 64'(act_valid), 64'd0);
    checkVal("s4_sr_held", 64'(tdo), 64'd1);
    tdi = 1'b0; vs_sdr = 1'b1; tick();
    checkVal("s4_sdr_idle", 64'(tdo), 64'd1);
    vs_udr = 1'b1; tick();
    checkVal("s4_udr_idle", 64'(act_valid), 64'd0);
    doCdr();
    checkVal("s4_ir_updated", 64'(tdo), 64'(chan(2'd2) & 38'd1));

    // Scenario 5: reset mid-scan with an action pending
    act_ready = 1'b0;
    doCdr();
    vs_udr = 1'b1; tick();
    checkVal("s5_pending", 64'(act_valid), 64'd1);
    doCdr();
    for (int i = 0; i < 10; i++) doSdr(1'b1);
    reset = 1'b1; tick();
    reset = 1'b0;
    sb.delete();
    msr = '0; mcnt = '0; mir = '0;
    checkVal("s5_st_idle",   64'(st_idle),   64'd1);
    checkVal("s5_tdo",       64'(tdo),       64'd0);
    checkVal("s5_jdo",       64'(jdo),       64'd0);
    checkVal("s5_valid",     64'(act_valid), 64'd0);
    checkVal("s5_ch",        64'(act_ch),    64'd0);
    checkVal("s5_take",      64'(act_take),  64'd0);
    checkVal("s5_short",     64'(act_short), 64'd0);
    checkVal("s5_overflow",  64'(overflow),  64'd0);
    vs_udr = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      checkVal($sformatf("s5_no_action_%0d", i), 64'(act_valid), 64'd0);
      tick();
    end
    act_ready = 1'b1; tick();
    checkVal("s5_no_action_ready", 64'(act_valid), 64'd0);

    checkVal("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/jtag_debug_scan_engine.md
JTAG_DEBUG_SCAN_ENGINE -- requirements
Module: jtag_debug_scan_engine

Interface
REQ-001 Parameter IR_W, default 2, instruction register width; NUM_CH = 2**IR_W capture/action channels.
REQ-002 Parameter DR_W, default 38, data shift register width, legal range 8..64.
REQ-003 clk  in  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ir_in  in  IR_W  instruction value presented with vs_uir.
REQ-006 vs_uir, vs_cdr, vs_sdr, vs_udr  in  1 each  single-cycle update-IR, capture-DR, shift-DR, update-DR strobes, already in the clk domain.
REQ-007 tdi  in  1  serial data in, valid with vs_sdr.
REQ-008 tdo  out  1  serial data out, equal to sr[0].
REQ-009 capture_data  in  NUM_CH*DR_W  per-channel capture words; channel k occupies bits [k*DR_W +: DR_W].
REQ-010 jdo  out  DR_W  last accepted update word.
REQ-011 act_valid  out  1; act_ready  in  1  action handshake.
REQ-012 act_ch  out  IR_W; act_take  out  1; act_short  out  1  action qualifiers, stable while act_valid.
REQ-013 overflow  out  1  sticky lost-update flag; clr_overflow  in  1  clears it.
REQ-014 st_idle  out  1  high when the FSM is in IDLE.

Function
REQ-015 FSM states are IDLE and SHIFT; ir_q (IR_W) SHALL latch ir_in on every vs_uir, in any state.
REQ-016 One strobe per cycle SHALL be processed, with priority vs_uir > vs_udr > vs_sdr > vs_cdr; lower-priority strobes in the same cycle are ignored.
REQ-017 vs_uir in SHIFT SHALL abort the scan: the FSM returns to IDLE, and sr and cnt hold.
REQ-018 vs_cdr in IDLE or SHIFT SHALL load sr with capture slice ir_q, clear cnt, and enter SHIFT.
REQ-019 vs_sdr in SHIFT SHALL set sr <= {tdi, sr[DR_W-1:1]} and increment cnt, saturating at DR_W; cnt is $clog2(DR_W+1) bits wide.
REQ-020 vs_sdr or vs_udr in IDLE SHALL be ignored.
REQ-021 vs_udr in SHIFT with act_valid low SHALL, on the next edge, set jdo <= sr, act_ch <= ir_q, act_take <= sr[DR_W-1], act_short <= (cnt != DR_W), assert act_valid, and enter IDLE.
REQ-022 vs_udr in SHIFT with act_valid high SHALL set overflow, leave jdo and the act_* qualifiers unchanged, and enter IDLE.
REQ-023 act_valid SHALL stay high until the first cycle with act_valid and act_ready both high, then deassert on the next edge; latency from vs_udr to act_valid is 1 cycle.
REQ-024 A vs_udr in the same cycle as a completing transfer (valid and ready both high) SHALL be treated as accepted, not as overflow.
REQ-025 overflow SHALL clear on clr_overflow; when a set event and clr_overflow occur together, set wins.
REQ-026 tdo SHALL be combinational from sr[0]; jdo SHALL change only on an accepted update.

Reset
REQ-027 reset SHALL force: state IDLE, st_idle 1, sr 0, cnt 0, ir_q 0, jdo 0, act_valid 0, act_ch 0, act_take 0, act_short 0, overflow 0.
REQ-028 reset asserted mid-scan or with act_valid pending SHALL discard the scan and the pending action, with no act_valid pulse after release.

Verification
REQ-029 Scenario 1, full scan: DR_W=38; uir ir_in=2; cdr with slice2=0x2A_AAAA_AAAA; 38 sdr with tdi=1; udr -> tdo sequence 0,1,0,1...; then jdo=0x3F_FFFF_FFFF, act_ch=2, act_take=1, act_short=0, act_valid 1 cycle after udr.
REQ-030 Scenario 2, short scan: cdr, then 5 sdr, then udr -> act_short=1 and jdo = capture word shifted by 5 with the tdi bits in [37:33].
REQ-031 Scenario 3, backpressure and overflow: act_ready held 0, two complete scans -> overflow=1 and jdo still equal to the first word; clr_overflow -> overflow=0.
REQ-032 Scenario 4, simultaneous strobes: uir, udr and sdr in one cycle -> only ir_q updates, the scan is aborted, no act_valid; sdr in IDLE -> sr unchanged.
REQ-033 Scenario 5, reset mid-scan: reset after 10 sdr -> st_idle=1, every output 0, and a later udr without cdr produces no action.
